range_merger_8: RTL

//  Consumer end of the sorter_8 stream. It accepts 8-lane batches of tuple_pair_t ranges
//  ([first,second], inclusive), ascending by .first across the whole job, and drains them one

---
 rtl/aoc5_pkg.sv | 36 +++
 rtl/pair_serializer_8.sv | 61 ++++++
 rtl/range_merger_8.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aoc5_pkg.sv
// Shared types for the AoC day 5 range pipeline (sorter_8 -> range_merger_8).
// Holds the range pair type, the swap result type and the compare/swap helper.
package aoc5_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LANES      = 8;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] first;
        logic [DATA_WIDTH-1:0] second;
    } tuple_pair_t;

    typedef struct packed {
        logic        swapped;
        tuple_pair_t lo;
        tuple_pair_t hi;
    } swp_tuple_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_DONE
    } merge_state_t;

    // Orders two ranges by .first; ties keep the original order.
    function automatic swp_tuple_pair_t cmp_swp(input tuple_pair_t a, input tuple_pair_t b);
        swp_tuple_pair_t r;
        r.swapped = (b.first < a.first);
        r.lo      = r.swapped ? b : a;
        r.hi      = r.swapped ? a : b;
        return r;
    endfunction

endpackage

// File: rtl/pair_serializer_8.sv
// Registers one 8-lane batch and presents it as a one-pair-per-cycle stream.
// An empty final batch is presented as a single marker element with has_pair=0.
module pair_serializer_8
    import aoc5_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  tuple_pair_t [LANES-1:0] in_pairs,
    input  logic [CNT_W-1:0]        in_count,
    input  logic                    in_last,
    output logic                    s_valid,
    output logic                    s_has_pair,
    output tuple_pair_t             s_pair,
    output logic                    last_pair,
    input  logic                    s_ready
);

    localparam int IDX_W = $clog2(LANES);

    tuple_pair_t [LANES-1:0] buf_pairs;
    logic [CNT_W-1:0]        buf_count;
    logic [CNT_W-1:0]        idx;
    logic                    buf_last;
    logic                    buf_full;
    logic                    final_lane;
    logic                    in_accept;

    assign s_valid    = buf_full;
    assign s_has_pair = (buf_count != '0);
    assign s_pair     = buf_pairs[idx[IDX_W-1:0]];
    assign final_lane = (buf_count == '0) || (idx == buf_count - 1'b1);
    assign last_pair  = buf_last && final_lane;
    // Refill on the same edge the last buffered lane leaves: no bubble between batches.
    assign in_ready   = !buf_full || (s_ready && final_lane);
    assign in_accept  = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_full  <= 1'b0;
            buf_count <= '0;
            buf_last  <= 1'b0;
            idx       <= '0;
        end else if (in_accept) begin
            buf_full  <= (in_count != '0) || in_last;
            buf_count <= in_count;
            buf_last  <= in_last;
            idx       <= '0;
        end else if (s_valid && s_ready) begin
            if (final_lane) buf_full <= 1'b0;
            else            idx      <= idx + 1'b1;
        end
    end

    // NOTE: lane data is qualified by buf_full, so it carries no reset and stays a plain register bank.
    always_ff @(posedge clock) begin
        if (in_accept) buf_pairs <= in_pairs;
    end

endmodule

// File: rtl/range_merger_8.sv
// Coalesces a sorted range stream and accumulates total covered length.
// Define RANGE_MERGE_ADJACENT_EN to also merge touching ranges (first == cur.second+1).
module range_merger_8
    import aoc5_pkg::*;
#(
    parameter int TOTAL_W = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  tuple_pair_t [LANES-1:0] in_pairs,
    input  logic [CNT_W-1:0]        in_count,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output tuple_pair_t             out_pair,
    output logic [TOTAL_W-1:0]      total_len,
    output logic                    done
);

    logic         lane_valid, lane_has_pair, lane_last, lane_ready;
    tuple_pair_t  lane_pair;
    merge_state_t state, state_next;
    tuple_pair_t  cur, cur_next, emit_pair;
    logic         cur_valid, cur_valid_next;
    logic         emit, slot_free, merge_hit, in_accept;
    logic [TOTAL_W-1:0] emit_len;

    pair_serializer_8 u_ser (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pairs   (in_pairs),
        .in_count   (in_count),
        .in_last    (in_last),
        .s_valid    (lane_valid),
        .s_has_pair (lane_has_pair),
        .s_pair     (lane_pair),
        .last_pair  (lane_last),
        .s_ready    (lane_ready)
    );

    assign in_accept = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign emit_len  = TOTAL_W'(emit_pair.second) - TOTAL_W'(emit_pair.first) + TOTAL_W'(1);

`ifdef RANGE_MERGE_ADJACENT_EN
    // Extra bit keeps cur.second+1 from wrapping at all-ones.
    assign merge_hit = {1'b0, lane_pair.first} <= ({1'b0, cur.second} + 1'b1);
`else
    assign merge_hit = lane_pair.first <= cur.second;
`endif

    // A lane is consumed unless it needs to emit while the output slot is occupied.
    always_comb begin
        lane_ready = 1'b0;
        if (lane_valid) begin
            case (state)
                ST_IDLE:  lane_ready = 1'b1;
                ST_ACCUM: lane_ready = !lane_has_pair || merge_hit || slot_free;
                default:  lane_ready = 1'b0;
            endcase
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        cur_next       = cur;
        cur_valid_next = cur_valid;
        emit           = 1'b0;
        emit_pair      = cur;
        case (state)
            ST_IDLE: begin
                if (lane_ready) begin
                    if (lane_has_pair) begin
                        cur_next       = lane_pair;
                        cur_valid_next = 1'b1;
                    end
                    state_next = (lane_last || !lane_has_pair) ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (lane_ready) begin
                    if (lane_has_pair) begin
                        if (merge_hit) begin
                            if (lane_pair.second > cur.second) cur_next.second = lane_pair.second;
                        end else begin
                            emit     = 1'b1;
                            cur_next = lane_pair;
                        end
                    end
                    if (lane_last) state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!cur_valid) begin
                    state_next = ST_DONE;
                end else if (slot_free) begin
                    emit           = 1'b1;
                    cur_valid_next = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (in_accept) begin
                    state_next     = ST_IDLE;
                    cur_valid_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            cur_valid <= 1'b0;
            out_valid <= 1'b0;
            out_pair  <= '0;
            total_len <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cur       <= cur_next;
            cur_valid <= cur_valid_next;
            done      <= (state_next == ST_DONE);
            if (emit) begin
                out_valid <= 1'b1;
                out_pair  <= emit_pair;
                total_len <= total_len + emit_len;
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (state == ST_DONE && in_accept) total_len <= '0;
            end
        end
    end

endmodule
